lbreg_mc: RTL and testbench

//  Multi-channel local-bus register file for the qubic top level; it replaces the fixed single regmap.

---
 rtl/lbreg_mc_pkg.sv | 19 +
 rtl/lbreg_mc_chan.sv | 43 ++++
 rtl/lbreg_mc.sv | 159 +++++++++++++++
 tb/tb_lbreg_mc.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lbreg_mc_pkg.sv
// Shared constants and types for the multi-channel local-bus register file.
package lbreg_mc_pkg;

  localparam logic [7:0]  LB_CMD_WR    = 8'h00;
  localparam logic [7:0]  LB_CMD_RD    = 8'h10;

  localparam logic [23:0] ADDR_COMMIT  = 24'h800000;
  localparam logic [23:0] ADDR_PENDING = 24'h800001;
  localparam logic [23:0] ADDR_ID      = 24'h800002;
  localparam logic [23:0] ADDR_ERRCNT  = 24'h800003;

  typedef enum logic [1:0] {IDLE, RD1, RD2} lbreg_state_t;

  // Decoded target of an access, captured at read accept.
  typedef enum logic [2:0] {
    SEL_CHAN, SEL_COMMIT, SEL_PEND, SEL_ID, SEL_ERRC, SEL_UNMAP
  } lbreg_sel_t;

endpackage

// File: rtl/lbreg_mc_chan.sv
// One channel bank: NREG shadow registers, NREG active registers, pending flag.
module lbreg_mc_chan
  import lbreg_mc_pkg::*;
#(
  parameter int NREG = 16,
  parameter int DW   = 32,
  parameter int RW   = $clog2(NREG)
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     wr_en,
  input  logic [RW-1:0]            wr_reg,
  input  logic [DW-1:0]            wr_data,
  input  logic                     commit,
  input  logic [RW-1:0]            rd_reg,
  output logic [DW-1:0]            rd_data,
  output logic [NREG-1:0][DW-1:0]  act_o,
  output logic                     pending_o
);

  logic [NREG-1:0][DW-1:0] shadow_q, act_q;
  logic                    pending_q, pending_d;

  // A write in the same cycle as a commit wins: the new value is still uncommitted.
  assign pending_d = wr_en | (pending_q & ~commit);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shadow_q  <= '0;
      act_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      if (commit) act_q <= shadow_q;
      if (wr_en)  shadow_q[wr_reg] <= wr_data;
      pending_q <= pending_d;
    end
  end

  assign rd_data   = shadow_q[rd_reg];
  assign act_o     = act_q;
  assign pending_o = pending_q;

endmodule

// File: rtl/lbreg_mc.sv
// Multi-channel double-buffered local-bus register file.
// Optional error counter at 0x800003 enabled by defining LBREG_MC_ERRCNT_EN.
module lbreg_mc
  import lbreg_mc_pkg::*;
#(
  parameter int LBCWIDTH = 8,
  parameter int LBAWIDTH = 24,
  parameter int LBDWIDTH = 32,
  parameter int NCH      = 8,
  parameter int NREG     = 16
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          lb_valid,
  output logic                          lb_ready,
  input  logic [LBCWIDTH-1:0]           lb_cmd,
  input  logic [LBAWIDTH-1:0]           lb_addr,
  input  logic [LBDWIDTH-1:0]           lb_wdata,
  output logic                          lb_rvalid,
  output logic [LBDWIDTH-1:0]           lb_rdata,
  output logic                          lb_rerr,
  input  logic [NCH-1:0]                commit_trig,
  output logic [NCH-1:0]                pending,
  output logic [NCH*NREG*LBDWIDTH-1:0]  act_regs
);

  localparam int RW = $clog2(NREG);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [15:0] ID_NREG = 16'(NREG);
  localparam logic [15:0] ID_NCH  = 16'(NCH);

  lbreg_state_t state_q, state_d;
  lbreg_sel_t   a_sel, rd_sel_q;
  logic [CW-1:0] a_ch, rd_ch_q;
  logic [RW-1:0] a_reg, rd_reg_q;
  logic          xfer, is_wr, is_rd, wr_chan, commit_wr;
  logic [NCH-1:0] commit_mask;
  logic [NCH-1:0][LBDWIDTH-1:0] chan_rd;
  logic [LBDWIDTH-1:0] rmux, rdata_q;
  logic          rerr_d, rerr_q, rvalid_q;

  assign a_reg = lb_addr[RW-1:0];
  assign a_ch  = lb_addr[RW+CW-1:RW];

  always_comb begin
    a_sel = SEL_UNMAP;
    if (!lb_addr[LBAWIDTH-1]) begin
      if ((lb_addr >> (RW+CW)) == '0 && int'(a_ch) < NCH) a_sel = SEL_CHAN;
    end else begin
      case (lb_addr)
        ADDR_COMMIT:  a_sel = SEL_COMMIT;
        ADDR_PENDING: a_sel = SEL_PEND;
        ADDR_ID:      a_sel = SEL_ID;
`ifdef LBREG_MC_ERRCNT_EN
        ADDR_ERRCNT:  a_sel = SEL_ERRC;
`endif
        default:      a_sel = SEL_UNMAP;
      endcase
    end
  end

  assign lb_ready    = (state_q == IDLE);
  assign xfer        = lb_valid & lb_ready;
  assign is_wr       = (lb_cmd == LB_CMD_WR);
  assign is_rd       = (lb_cmd == LB_CMD_RD);
  assign wr_chan     = xfer & is_wr & (a_sel == SEL_CHAN);
  assign commit_wr   = xfer & is_wr & (a_sel == SEL_COMMIT);
  assign commit_mask = commit_trig | ({NCH{commit_wr}} & lb_wdata[NCH-1:0]);

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    lbreg_mc_chan #(.NREG(NREG), .DW(LBDWIDTH), .RW(RW)) u_chan (
      .clk       (clk),
      .rstn      (rstn),
      .wr_en     (wr_chan && (a_ch == CW'(c))),
      .wr_reg    (a_reg),
      .wr_data   (lb_wdata),
      .commit    (commit_mask[c]),
      .rd_reg    (rd_reg_q),
      .rd_data   (chan_rd[c]),
      .act_o     (act_regs[c*NREG*LBDWIDTH +: NREG*LBDWIDTH]),
      .pending_o (pending[c])
    );
  end

`ifdef LBREG_MC_ERRCNT_EN
  logic [15:0] errcnt_q, errcnt_d;
  logic        err_ev, err_clr;

  // Illegal commands count regardless of address; legal ones only when unmapped.
  assign err_ev  = xfer & ((~is_wr & ~is_rd) | (a_sel == SEL_UNMAP));
  assign err_clr = xfer & is_wr & (a_sel == SEL_ERRC);

  always_comb begin
    errcnt_d = errcnt_q;
    if (err_clr)                              errcnt_d = {15'd0, err_ev};
    else if (err_ev && errcnt_q != 16'hFFFF)  errcnt_d = errcnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) errcnt_q <= '0;
    else       errcnt_q <= errcnt_d;
  end
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (xfer && is_rd) state_d = RD1;
      RD1:     state_d = RD2;
      RD2:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rmux   = '0;
    rerr_d = 1'b0;
    case (rd_sel_q)
      SEL_CHAN:  rmux = chan_rd[rd_ch_q];
      SEL_PEND:  rmux[NCH-1:0] = pending;
      SEL_ID:    rmux = LBDWIDTH'({ID_NREG, ID_NCH});
`ifdef LBREG_MC_ERRCNT_EN
      SEL_ERRC:  rmux[15:0] = errcnt_q;
`endif
      SEL_UNMAP: rerr_d = 1'b1;
      default:   rmux = '0;
    endcase
  end

  // Data is registered in RD1 and presented with the strobe one cycle later.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      rd_sel_q <= SEL_UNMAP;
      rd_ch_q  <= '0;
      rd_reg_q <= '0;
      rdata_q  <= '0;
      rerr_q   <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (xfer && is_rd) begin
        rd_sel_q <= a_sel;
        rd_ch_q  <= a_ch;
        rd_reg_q <= a_reg;
      end
      if (state_q == RD1) begin
        rdata_q <= rmux;
        rerr_q  <= rerr_d;
      end
      rvalid_q <= (state_q == RD2);
    end
  end

  assign lb_rvalid = rvalid_q;
  assign lb_rdata  = rdata_q;
  assign lb_rerr   = rerr_q;

endmodule

// File: tb/tb_lbreg_mc.sv
// Randomized self-checking bench for lbreg_mc against an array-based register model.
module tb_lbreg_mc;

  localparam int NCH  = 8;
  localparam int NREG = 16;
  localparam int AW   = NCH*NREG*32;
`ifdef LBREG_MC_ERRCNT_EN
  localparam bit ERRC_EN = 1'b1;
`else
  localparam bit ERRC_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic           lb_valid = 1'b0;
  logic           lb_ready;
  logic [7:0]     lb_cmd = 8'h00;
  logic [23:0]    lb_addr = '0;
  logic [31:0]    lb_wdata = '0;
  logic           lb_rvalid;
  logic [31:0]    lb_rdata;
  logic           lb_rerr;
  logic [NCH-1:0] commit_trig = '0;
  logic [NCH-1:0] pending;
  logic [AW-1:0]  act_regs;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0]    m_sh  [NCH][NREG];
  logic [31:0]    m_act [NCH][NREG];
  logic [NCH-1:0] m_pend;
  int             m_err;

  lbreg_mc #(.LBCWIDTH(8), .LBAWIDTH(24), .LBDWIDTH(32), .NCH(NCH), .NREG(NREG)) dut (
    .clk(clk), .rstn(rstn), .lb_valid(lb_valid), .lb_ready(lb_ready), .lb_cmd(lb_cmd),
    .lb_addr(lb_addr), .lb_wdata(lb_wdata), .lb_rvalid(lb_rvalid), .lb_rdata(lb_rdata),
    .lb_rerr(lb_rerr), .commit_trig(commit_trig), .pending(pending), .act_regs(act_regs)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  task automatic model_reset();
    for (int c = 0; c < NCH; c++)
      for (int r = 0; r < NREG; r++) begin
        m_sh[c][r]  = '0;
        m_act[c][r] = '0;
      end
    m_pend = '0;
    m_err  = 0;
  endtask

  function automatic bit mapped(input logic [23:0] a);
    return (a < NCH*NREG) || a == 24'h800000 || a == 24'h800001 || a == 24'h800002 ||
           (ERRC_EN && a == 24'h800003);
  endfunction

  function automatic void model_read(input logic [23:0] a, output logic [31:0] d, output logic e);
    d = '0;
    e = 1'b0;
    if (a < NCH*NREG)                  d = m_sh[a / NREG][a % NREG];
    else if (a == 24'h800000)          d = '0;
    else if (a == 24'h800001)          d = 32'(m_pend);
    else if (a == 24'h800002)          d = 32'(NREG * 65536 + NCH);
    else if (ERRC_EN && a == 24'h800003) d = 32'(m_err);
    else                               e = 1'b1;
  endfunction

  function automatic logic [AW-1:0] exp_act();
    logic [AW-1:0] v;
    for (int c = 0; c < NCH; c++)
      for (int r = 0; r < NREG; r++) v[(c*NREG+r)*32 +: 32] = m_act[c][r];
    return v;
  endfunction

  function automatic int first_diff();
    logic [AW-1:0] v;
    v = exp_act();
    for (int w = 0; w < NCH*NREG; w++)
      if (act_regs[w*32 +: 32] !== v[w*32 +: 32]) return w;
    return 0;
  endfunction

  function automatic void err_inc();
    if (m_err < 65535) m_err = m_err + 1;
  endfunction

  // One bus cycle (optionally idle) plus hardware trigger, then model update.
  task automatic bus_cycle(input bit v, input logic [7:0] cmd, input logic [23:0] a,
                           input logic [31:0] wd, input logic [NCH-1:0] trig);
    logic [NCH-1:0] mask;
    @(negedge clk);
    lb_valid = v; lb_cmd = cmd; lb_addr = a; lb_wdata = wd; commit_trig = trig;
    @(posedge clk); #1;
    lb_valid = 1'b0; commit_trig = '0;
    mask = trig;
    if (v && cmd == 8'h00 && a == 24'h800000) mask = mask | wd[NCH-1:0];
    for (int c = 0; c < NCH; c++)
      if (mask[c]) begin
        for (int r = 0; r < NREG; r++) m_act[c][r] = m_sh[c][r];
        m_pend[c] = 1'b0;
      end
    if (v && cmd == 8'h00 && a < NCH*NREG) begin
      m_sh[a / NREG][a % NREG] = wd;
      m_pend[a / NREG] = 1'b1;
    end
    if (v) begin
      if ((cmd != 8'h00 && cmd != 8'h10) || !mapped(a)) err_inc();
      if (cmd == 8'h00 && ERRC_EN && a == 24'h800003) m_err = 0;
    end
  endtask

  task automatic do_read(input logic [23:0] a, output logic [31:0] d, output logic e, output int lat);
    @(negedge clk);
    lb_valid = 1'b1; lb_cmd = 8'h10; lb_addr = a;
    @(posedge clk); #1;
    lb_valid = 1'b0;
    if (!mapped(a)) err_inc();
    lat = -1; d = 'x; e = 1'bx;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (lb_rvalid) begin
        lat = k; d = lb_rdata; e = lb_rerr;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] d; logic e; int lat;
    rstn = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;
    n_tests++; if (act_regs !== '0) begin n_fail++; $display("FAIL reset_act word %0d nonzero", first_diff()); end
    n_tests++; if (pending !== '0) begin n_fail++; $display("FAIL reset_pending got %h want 0", pending); end
    n_tests++; if (lb_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", lb_ready); end
    n_tests++; if (lb_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid got %b want 0", lb_rvalid); end
    do_read(24'h000000, d, e, lat);
    n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL reset_read_lat got %0d want 2", lat); end
    n_tests++; if (d !== 32'h0 || e !== 1'b0) begin n_fail++; $display("FAIL reset_read got %h/%b want 0/0", d, e); end
  endtask

  task automatic test_bus_commit();
    logic [31:0] d; logic e; int lat;
    bus_cycle(1, 8'h00, 24'h000025, 32'hDEADBEEF, '0);
    n_tests++; if (pending !== 8'h04) begin n_fail++; $display("FAIL wr_pending got %h want 04", pending); end
    n_tests++; if (act_regs[(2*NREG+5)*32 +: 32] !== 32'h0) begin n_fail++;
      $display("FAIL wr_act_unchanged got %h want 0", act_regs[(2*NREG+5)*32 +: 32]); end
    bus_cycle(1, 8'h00, 24'h800000, 32'h4, '0);
    n_tests++; if (act_regs[(2*NREG+5)*32 +: 32] !== 32'hDEADBEEF) begin n_fail++;
      $display("FAIL commit_act got %h want deadbeef", act_regs[(2*NREG+5)*32 +: 32]); end
    n_tests++; if (pending !== 8'h00) begin n_fail++; $display("FAIL commit_pending got %h want 00", pending); end
    do_read(24'h000025, d, e, lat);
    n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL read_lat got %0d want 2", lat); end
    n_tests++; if (d !== 32'hDEADBEEF || e !== 1'b0) begin n_fail++;
      $display("FAIL read_ch2r5 got %h/%b want deadbeef/0", d, e); end
  endtask

  task automatic test_same_edge();
    logic [31:0] d; logic e; int lat;
    bus_cycle(1, 8'h00, 24'h000010, 32'h3, '0);
    bus_cycle(0, 8'h00, 24'h0, 32'h0, 8'h02);
    bus_cycle(1, 8'h00, 24'h000010, 32'h5, 8'h02);
    n_tests++; if (act_regs[(1*NREG)*32 +: 32] !== 32'h3) begin n_fail++;
      $display("FAIL same_edge_act got %h want 3", act_regs[(1*NREG)*32 +: 32]); end
    n_tests++; if (pending[1] !== 1'b1) begin n_fail++; $display("FAIL same_edge_pending got %b want 1", pending[1]); end
    do_read(24'h000010, d, e, lat);
    n_tests++; if (d !== 32'h5 || lat !== 2) begin n_fail++; $display("FAIL same_edge_shadow got %h lat %0d want 5 lat 2", d, lat); end
    bus_cycle(0, 8'h00, 24'h0, 32'h0, 8'h02);
    n_tests++; if (act_regs[(1*NREG)*32 +: 32] !== 32'h5) begin n_fail++;
      $display("FAIL trig_act got %h want 5", act_regs[(1*NREG)*32 +: 32]); end
    n_tests++; if (pending[1] !== 1'b0) begin n_fail++; $display("FAIL trig_pending got %b want 0", pending[1]); end
  endtask

  task automatic test_unmapped();
    logic [31:0] d; logic e; int lat;
    do_read(24'h000080, d, e, lat);
    n_tests++; if (d !== 32'h0 || e !== 1'b1 || lat !== 2) begin n_fail++;
      $display("FAIL unmapped_read got %h/%b lat %0d want 0/1 lat 2", d, e, lat); end
    bus_cycle(1, 8'h00, 24'h000080, 32'hA5A5A5A5, '0);
    bus_cycle(1, 8'h00, 24'h800001, 32'hFFFFFFFF, '0);
    bus_cycle(1, 8'h00, 24'h800002, 32'h12345678, '0);
    n_tests++; if (act_regs !== exp_act()) begin n_fail++; $display("FAIL unmapped_wr_act word %0d differs", first_diff()); end
    n_tests++; if (pending !== m_pend) begin n_fail++; $display("FAIL unmapped_wr_pending got %h want %h", pending, m_pend); end
    do_read(24'h800002, d, e, lat);
    n_tests++; if (d !== 32'h00100008 || e !== 1'b0) begin n_fail++; $display("FAIL id_read got %h want 00100008", d); end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    @(negedge clk);
    lb_valid = 1'b1; lb_cmd = 8'h10; lb_addr = 24'h800002;
    for (int k = 0; k < 9; k++) begin
      @(posedge clk); #1;
      if (lb_rvalid) pulses++;
      if (k == 8) lb_valid = 1'b0;
    end
    n_tests++; if (pulses !== 3) begin n_fail++; $display("FAIL back_to_back pulses got %0d want 3", pulses); end
    @(posedge clk); #1;
    n_tests++; if (lb_ready !== 1'b1 || lb_rvalid !== 1'b0) begin n_fail++;
      $display("FAIL b2b_idle ready %b rvalid %b want 1/0", lb_ready, lb_rvalid); end
  endtask

  task automatic test_random();
    logic [31:0] d, ed; logic e, ee; int lat, op;
    logic [23:0] a;
    logic [NCH-1:0] trig;
    logic [23:0] odd [8];
    odd = '{24'h000080, 24'h0001A3, 24'h7FFFFF, 24'h800004, 24'hFFFFFF, 24'h800001, 24'h800003, 24'h800000};
    for (int i = 0; i < 300; i++) begin
      op   = int'($urandom_range(0, 9));
      trig = ($urandom_range(0, 3) == 0) ? NCH'($urandom) : '0;
      if (op >= 7) begin
        a = ($urandom_range(0, 2) != 0) ? 24'($urandom_range(0, NCH*NREG-1)) : odd[$urandom_range(0, 7)];
        model_read(a, ed, ee);
        do_read(a, d, e, lat);
        n_tests++; if (d !== ed || e !== ee || lat !== 2) begin n_fail++;
          $display("FAIL rand_read addr %h got %h/%b lat %0d want %h/%b lat 2", a, d, e, lat, ed, ee); end
      end else begin
        case (op)
          0, 1, 2, 3: bus_cycle(1, 8'h00, 24'($urandom_range(0, NCH*NREG-1)), $urandom, trig);
          4:          bus_cycle(1, 8'h00, 24'h800000, $urandom, trig);
          5:          bus_cycle(1, 8'h00, odd[$urandom_range(0, 7)], $urandom, trig);
          default:    bus_cycle(0, 8'h00, 24'h0, 32'h0, trig);
        endcase
        n_tests++; if (act_regs !== exp_act()) begin n_fail++; $display("FAIL rand_act op %0d word %0d differs", i, first_diff()); end
        n_tests++; if (pending !== m_pend) begin n_fail++; $display("FAIL rand_pending op %0d got %h want %h", i, pending, m_pend); end
      end
    end
  endtask

  task automatic test_errcnt();
    logic [31:0] d; logic e; int lat; int pulses = 0;
    bus_cycle(1, 8'h55, 24'h000025, 32'h11111111, '0);
    for (int k = 0; k < 3; k++) begin @(posedge clk); #1; if (lb_rvalid) pulses++; end
    n_tests++; if (pulses !== 0) begin n_fail++; $display("FAIL illegal_cmd_rvalid pulses got %0d want 0", pulses); end
    n_tests++; if (act_regs !== exp_act() || pending !== m_pend) begin n_fail++;
      $display("FAIL illegal_cmd_state pending got %h want %h", pending, m_pend); end
`ifdef LBREG_MC_ERRCNT_EN
    bus_cycle(1, 8'h00, 24'h800003, 32'h0, '0);
    bus_cycle(1, 8'h55, 24'h000000, 32'h0, '0);
    do_read(24'h800003, d, e, lat);
    n_tests++; if (d !== 32'd1 || e !== 1'b0) begin n_fail++; $display("FAIL errcnt_one got %h/%b want 1/0", d, e); end
    @(negedge clk);
    lb_valid = 1'b1; lb_cmd = 8'h55; lb_addr = 24'h0;
    repeat (65540) @(posedge clk);
    #1 lb_valid = 1'b0;
    do_read(24'h800003, d, e, lat);
    n_tests++; if (d !== 32'h0000FFFF) begin n_fail++; $display("FAIL errcnt_sat got %h want 0000ffff", d); end
    bus_cycle(1, 8'h00, 24'h800003, 32'hFFFFFFFF, '0);
    do_read(24'h800003, d, e, lat);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL errcnt_clear got %h want 0", d); end
`else
    do_read(24'h800003, d, e, lat);
    n_tests++; if (d !== 32'h0 || e !== 1'b1 || lat !== 2) begin n_fail++;
      $display("FAIL errcnt_unmapped got %h/%b lat %0d want 0/1 lat 2", d, e, lat); end
`endif
  endtask

  task automatic test_reset_midread();
    logic [31:0] d; logic e; int lat; int pulses = 0;
    do_read(24'h800002, d, e, lat);
    @(negedge clk);
    lb_valid = 1'b1; lb_cmd = 8'h10; lb_addr = 24'h000025;
    @(posedge clk); #1;
    lb_valid = 1'b0;
    rstn = 1'b0;
    #1;
    n_tests++; if (act_regs !== '0 || pending !== '0) begin n_fail++;
      $display("FAIL midrd_state pending got %h want 0", pending); end
    n_tests++; if (lb_rdata !== 32'h0 || lb_rerr !== 1'b0 || lb_rvalid !== 1'b0 || lb_ready !== 1'b1) begin n_fail++;
      $display("FAIL midrd_outputs rdata %h rerr %b rvalid %b ready %b want 0/0/0/1", lb_rdata, lb_rerr, lb_rvalid, lb_ready); end
    model_reset();
    for (int k = 0; k < 3; k++) begin @(posedge clk); #1; if (lb_rvalid) pulses++; end
    @(negedge clk); rstn = 1'b1;
    for (int k = 0; k < 3; k++) begin @(posedge clk); #1; if (lb_rvalid) pulses++; end
    n_tests++; if (pulses !== 0) begin n_fail++; $display("FAIL midrd_lost pulses got %0d want 0", pulses); end
    do_read(24'h800002, d, e, lat);
    n_tests++; if (d !== 32'h00100008 || lat !== 2) begin n_fail++;
      $display("FAIL midrd_id got %h lat %0d want 00100008 lat 2", d, lat); end
  endtask

  initial begin
    test_reset();
    test_bus_commit();
    test_same_edge();
    test_unmapped();
    test_back_to_back();
    test_random();
    test_errcnt();
    test_reset_midread();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
